cond_exec_stage: RTL and testbench
==================================

// Module: cond_exec_stage
// PURPOSE
//  Execute-stage consumer of the main decoder's control word in the pipelined ARM-subset core.
//  - Holds the ID/EX control pipeline register, with stall and flush.
//  - Keeps the architectural NZCV flags register.
//  - Evaluates the instruction's 4-bit condition field against the flags.
//  - Gates every side effect (PC write, reg write, mem write, flag write) so that failed
//    conditions become no-ops.
//  - Reports branch-taken to the hazard unit.
// PARAMETERS
//  CNT_W  16  width of the squashed-instruction counter (PERF_COUNT_EN only)
// PORTS
//  clk            in   1      core clock, rising edge
//  reset          in   1      asynchronous, active-high
//  stall_e        in   1      hold E-stage register contents
//  flush_e        in   1      load bubble into E stage
//  Cond_d         in   4      instr[31:28] of the instruction in D
//  PCS_d          in   1      decoder: writes PC (branch or Rd==15)
//  RegW_d         in   1      decoder: register write
//  MemW_d         in   1      decoder: memory write
//  MemtoReg_d     in   1      decoder: WB mux select
//  ALUSrc_d       in   1      decoder: immediate operand select
//  FlagW_d        in   2      decoder: [1]=update N,Z  [0]=update C,V
//  ALUControl_d   in   3      decoder ALU op
//  ALUFlags_e     in   4      {N,Z,C,V} from the E-stage ALU, same cycle
//  PCSrc_e        out  1      gated PC write
//  RegWrite_e     out  1      gated register write
//  MemWrite_e     out  1      gated memory write
//  MemtoReg_e     out  1      registered, ungated
//  ALUSrc_e       out  1      registered, ungated
//  ALUControl_e   out  3      registered, ungated
//  CondEx_e       out  1      condition passed AND E slot valid
//  BranchTaken_e  out  1      equals PCSrc_e; consumed by the hazard unit
//  Flags          out  4      current {N,Z,C,V}
//  squash_cnt     out  CNT_W  count of squashed valid instructions
// BEHAVIOUR
//  - Reset (async) state:
//    - All registered controls 0, valid_e=0, Cond_e=4'b1110, Flags=4'b0000, squash_cnt=0.
//    - Therefore every output reads 0 out of reset.
//  - Pipeline register update at posedge clk:
//    - flush_e: bubble (all controls 0, valid_e=0, Cond_e=AL). Flush wins over stall.
//    - else stall_e: hold.
//    - else capture the *_d inputs and set valid_e=1.
//  - Latency: a decoder word presented in cycle t drives the *_e outputs in cycle t+1.
//  - Condition table (N,Z,C,V = Flags):
//    - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
//    - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1
//    - 4'b1111 is reserved and evaluates to 0 (instruction squashed).
//  - Output gating:
//    - CondEx_e = valid_e & condpass.
//    - PCSrc_e/RegWrite_e/MemWrite_e = the registered bit & CondEx_e (combinational).
//  - Flag update at posedge clk, only when CondEx_e & !stall_e:
//    - Flags[3:2] <= ALUFlags_e[3:2] if FlagW_e[1].
//    - Flags[1:0] <= ALUFlags_e[1:0] if FlagW_e[0].
//    - Stalled cycles never write flags, so a held S-instruction updates exactly once.
//  - No flag bypass: a flag write made by instruction i is first visible to i+1 in the cycle
//    after i leaves E. Back-to-back CMP;BEQ therefore works without an interlock.
//  - Flush and update in the same edge: the flag update from the outgoing E instruction
//    still commits; only the incoming slot becomes a bubble.
//  - Reset mid-operation: immediate return to reset state; flags are lost.
// CONFIGURATION
//  - Macro PERF_COUNT_EN defined:
//    - squash_cnt increments at posedge clk when valid_e & !condpass & !stall_e.
//    - Saturates at all-ones.
//  - Macro PERF_COUNT_EN undefined: no counter logic; squash_cnt is tied to '0.
// STRUCTURE
//  - Package cond_pkg holds:
//    - the cond_t enum (EQ..AL, NV=4'hF);
//    - flag index localparams (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
//    - the ctrl_e_t packed struct for the E-stage control word;
//    - the CTRL_BUBBLE constant.
//  - Sub-module cond_check: purely combinational, (cond_t, Flags) -> condpass.
// TESTING
//  - Reset: assert reset mid-stream -> all outputs 0 and Flags=0 in the same cycle; Cond_e=AL.
//  - Pass/fail, EQ branch:
//    - Flags=0100 (Z), Cond_d=0000, PCS_d=1 -> next cycle PCSrc_e=1, BranchTaken_e=1.
//    - Same word with Flags=0000 -> all gated outputs 0; squash_cnt+1 when PERF_COUNT_EN is defined.
//  - Flag update: SUBS with FlagW_d=11, AL, ALUFlags_e=1001 -> Flags=1001 one edge later.
//    - Same word with FlagW_d=10 -> Flags[1:0] unchanged.
//  - Stall: hold a CMP-EQ in E for 3 cycles with ALUFlags_e=0100 -> Flags written once,
//    CondEx_e stable across the stall.
//  - Flush plus stall in the same cycle -> bubble wins: valid_e=0 and RegWrite_e=0 next cycle.
//  - Sweep all 16 condition codes x 16 flag values -> CondEx_e matches the condition table;
//    cond 1111 is always 0.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the execute-stage condition logic: condition codes,
// flag bit positions and the E-stage control word.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAGW_W = 2;
  localparam int unsigned ALUCTL_W = 3;

  typedef struct packed {
    cond_t                cond;
    logic                 pcs;
    logic                 regw;
    logic                 memw;
    logic                 memtoreg;
    logic                 alusrc;
    logic [FLAGW_W-1:0]   flagw;
    logic [ALUCTL_W-1:0]  alucontrol;
  } ctrl_e_t;

  // A bubble carries no side effects and an always-true condition.
  localparam ctrl_e_t CTRL_BUBBLE = '{
    cond:       AL,
    pcs:        1'b0,
    regw:       1'b0,
    memw:       1'b0,
    memtoreg:   1'b0,
    alusrc:     1'b0,
    flagw:      '0,
    alucontrol: '0
  };

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition code against {N,Z,C,V}.
module cond_check
  import cond_pkg::*;
(
  input  cond_t      cond,
  input  logic [3:0] flags,
  output logic       condpass
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    condpass = 1'b0;
    case (cond)
      EQ: condpass = z;
      NE: condpass = !z;
      CS: condpass = c;
      CC: condpass = !c;
      MI: condpass = n;
      PL: condpass = !n;
      VS: condpass = v;
      VC: condpass = !v;
      HI: condpass = c && !z;
      LS: condpass = !c || z;
      GE: condpass = (n == v);
      LT: condpass = (n != v);
      GT: condpass = !z && (n == v);
      LE: condpass = z || (n != v);
      AL: condpass = 1'b1;
      NV: condpass = 1'b0;
      default: condpass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute stage: ID/EX control register, NZCV flags and condition gating.
// Optional squashed-instruction counter enabled by defining PERF_COUNT_EN.
module cond_exec_stage
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic [3:0]        Cond_d,
  input  logic              PCS_d,
  input  logic              RegW_d,
  input  logic              MemW_d,
  input  logic              MemtoReg_d,
  input  logic              ALUSrc_d,
  input  logic [1:0]        FlagW_d,
  input  logic [2:0]        ALUControl_d,
  input  logic [3:0]        ALUFlags_e,
  output logic              PCSrc_e,
  output logic              RegWrite_e,
  output logic              MemWrite_e,
  output logic              MemtoReg_e,
  output logic              ALUSrc_e,
  output logic [2:0]        ALUControl_e,
  output logic              CondEx_e,
  output logic              BranchTaken_e,
  output logic [3:0]        Flags,
  output logic [CNT_W-1:0]  squash_cnt
);

  ctrl_e_t ctrl_e;
  logic    valid_e;
  logic    condpass;

  // ID/EX control register; flush takes priority over stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e  <= CTRL_BUBBLE;
      valid_e <= 1'b0;
    end else if (flush_e) begin
      ctrl_e  <= CTRL_BUBBLE;
      valid_e <= 1'b0;
    end else if (!stall_e) begin
      ctrl_e.cond       <= cond_t'(Cond_d);
      ctrl_e.pcs        <= PCS_d;
      ctrl_e.regw       <= RegW_d;
      ctrl_e.memw       <= MemW_d;
      ctrl_e.memtoreg   <= MemtoReg_d;
      ctrl_e.alusrc     <= ALUSrc_d;
      ctrl_e.flagw      <= FlagW_d;
      ctrl_e.alucontrol <= ALUControl_d;
      valid_e           <= 1'b1;
    end
  end

  cond_check u_cond_check (
    .cond     (ctrl_e.cond),
    .flags    (Flags),
    .condpass (condpass)
  );

  assign CondEx_e      = valid_e & condpass;
  assign PCSrc_e       = ctrl_e.pcs  & CondEx_e;
  assign RegWrite_e    = ctrl_e.regw & CondEx_e;
  assign MemWrite_e    = ctrl_e.memw & CondEx_e;
  assign BranchTaken_e = PCSrc_e;
  assign MemtoReg_e    = ctrl_e.memtoreg;
  assign ALUSrc_e      = ctrl_e.alusrc;
  assign ALUControl_e  = ctrl_e.alucontrol;

  // Flags commit even when the incoming slot is flushed; a stalled
  // instruction writes only on the cycle it finally leaves E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (CondEx_e && !stall_e) begin
      if (ctrl_e.flagw[1]) begin
        Flags[FLAG_N] <= ALUFlags_e[FLAG_N];
        Flags[FLAG_Z] <= ALUFlags_e[FLAG_Z];
      end
      if (ctrl_e.flagw[0]) begin
        Flags[FLAG_C] <= ALUFlags_e[FLAG_C];
        Flags[FLAG_V] <= ALUFlags_e[FLAG_V];
      end
    end
  end

`ifdef PERF_COUNT_EN
  // Saturating count of valid instructions whose condition failed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      squash_cnt <= '0;
    end else if (valid_e && !condpass && !stall_e && (squash_cnt != '1)) begin
      squash_cnt <= squash_cnt + CNT_W'(1);
    end
  end
`else
  assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed-vector bench for cond_exec_stage with hand-computed expectations.
module tb_cond_exec_stage;
  import cond_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall_e, flush_e;
  logic [3:0]       Cond_d;
  logic             PCS_d, RegW_d, MemW_d, MemtoReg_d, ALUSrc_d;
  logic [1:0]       FlagW_d;
  logic [2:0]       ALUControl_d;
  logic [3:0]       ALUFlags_e;
  logic             PCSrc_e, RegWrite_e, MemWrite_e, MemtoReg_e, ALUSrc_e;
  logic [2:0]       ALUControl_e;
  logic             CondEx_e, BranchTaken_e;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] squash_cnt;

  int n_vec = 0;
  int n_err = 0;

  cond_exec_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .Cond_d(Cond_d), .PCS_d(PCS_d), .RegW_d(RegW_d), .MemW_d(MemW_d),
    .MemtoReg_d(MemtoReg_d), .ALUSrc_d(ALUSrc_d), .FlagW_d(FlagW_d),
    .ALUControl_d(ALUControl_d), .ALUFlags_e(ALUFlags_e),
    .PCSrc_e(PCSrc_e), .RegWrite_e(RegWrite_e), .MemWrite_e(MemWrite_e),
    .MemtoReg_e(MemtoReg_e), .ALUSrc_e(ALUSrc_e), .ALUControl_e(ALUControl_e),
    .CondEx_e(CondEx_e), .BranchTaken_e(BranchTaken_e), .Flags(Flags),
    .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] c, input logic pcs, input logic regw,
                       input logic memw, input logic m2r, input logic asrc,
                       input logic [1:0] fw, input logic [2:0] alu);
    Cond_d = c; PCS_d = pcs; RegW_d = regw; MemW_d = memw;
    MemtoReg_d = m2r; ALUSrc_d = asrc; FlagW_d = fw; ALUControl_d = alu;
  endtask

  task automatic nop();
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b00, 3'd0);
  endtask

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return cf;
      4'h3: return ~cf;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return cf & ~z;
      4'h9: return ~cf | z;
      4'hA: return ~(n ^ v);
      4'hB: return n ^ v;
      4'hC: return ~z & ~(n ^ v);
      4'hD: return z | (n ^ v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [CNT_W-1:0] exp_cnt;
`ifdef PERF_COUNT_EN
    exp_cnt = CNT_W'(1);
`else
    exp_cnt = '0;
`endif
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0; ALUFlags_e = 4'h0;
    nop();
    #2;
    check("rst_pcsrc",  32'(PCSrc_e), 0);
    check("rst_regw",   32'(RegWrite_e), 0);
    check("rst_condex", 32'(CondEx_e), 0);
    check("rst_flags",  32'(Flags), 0);
    check("rst_alu",    32'(ALUControl_e), 0);
    check("rst_cnt",    32'(squash_cnt), 0);
    @(negedge clk);
    reset = 1'b0;

    // EQ branch taken with Z set
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b11, 3'd0); tick();
    ALUFlags_e = 4'b0100;
    set_d(4'h0, 1, 0, 0, 0, 0, 2'b00, 3'd0); tick();
    check("eq_flags",  32'(Flags), 32'h4);
    check("eq_pcsrc",  32'(PCSrc_e), 1);
    check("eq_btaken", 32'(BranchTaken_e), 1);
    check("eq_condex", 32'(CondEx_e), 1);
    check("eq_regw",   32'(RegWrite_e), 0);

    // EQ fails with Z clear
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b11, 3'd0); tick();
    ALUFlags_e = 4'b0000;
    set_d(4'h0, 1, 1, 1, 1, 1, 2'b00, 3'd0); tick();
    check("ne_flags",  32'(Flags), 0);
    check("ne_pcsrc",  32'(PCSrc_e), 0);
    check("ne_btaken", 32'(BranchTaken_e), 0);
    check("ne_regw",   32'(RegWrite_e), 0);
    check("ne_memw",   32'(MemWrite_e), 0);
    check("ne_condex", 32'(CondEx_e), 0);
    check("ne_m2r",    32'(MemtoReg_e), 1);
    check("ne_asrc",   32'(ALUSrc_e), 1);
    check("ne_cnt0",   32'(squash_cnt), 0);
    nop(); tick();
    check("ne_cnt1",   32'(squash_cnt), 32'(exp_cnt));

    // SUBS full flag update, then N/Z-only update
    set_d(4'hE, 0, 1, 0, 0, 0, 2'b11, 3'd1); tick();
    check("subs_alu",    32'(ALUControl_e), 1);
    check("subs_condex", 32'(CondEx_e), 1);
    ALUFlags_e = 4'b1001;
    nop(); tick();
    check("subs_flags", 32'(Flags), 32'h9);
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b10, 3'd1); tick();
    ALUFlags_e = 4'b0110;
    nop(); tick();
    check("nz_only_flags", 32'(Flags), 32'h5);

    // CMP-EQ held three cycles: flags written only when it leaves E
    set_d(4'h0, 0, 0, 0, 0, 0, 2'b11, 3'd2); tick();
    check("stall_condex0", 32'(CondEx_e), 1);
    stall_e = 1'b1; ALUFlags_e = 4'b0100;
    set_d(4'hE, 0, 1, 0, 0, 0, 2'b00, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_flags", i),  32'(Flags), 32'h5);
      check($sformatf("stall%0d_condex", i), 32'(CondEx_e), 1);
      check($sformatf("stall%0d_regw", i),   32'(RegWrite_e), 0);
    end
    stall_e = 1'b0;
    nop(); tick();
    check("stall_rel_flags", 32'(Flags), 32'h4);

    // Flush and stall together: bubble wins
    set_d(4'hE, 0, 1, 0, 0, 0, 2'b00, 3'd0); tick();
    check("fs_regw_pre", 32'(RegWrite_e), 1);
    flush_e = 1'b1; stall_e = 1'b1; tick();
    check("fs_valid",  32'(dut.valid_e), 0);
    check("fs_regw",   32'(RegWrite_e), 0);
    check("fs_condex", 32'(CondEx_e), 0);
    flush_e = 1'b0; stall_e = 1'b0;

    // Flush in the same edge as a flag write: the write still commits
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b11, 3'd0); tick();
    ALUFlags_e = 4'b1000; flush_e = 1'b1; tick();
    check("fu_flags",  32'(Flags), 32'h8);
    check("fu_condex", 32'(CondEx_e), 0);
    flush_e = 1'b0;

    // Asynchronous reset mid-stream
    set_d(4'hE, 1, 1, 1, 0, 0, 2'b00, 3'd5); tick();
    check("mr_pcsrc_pre", 32'(PCSrc_e), 1);
    #3 reset = 1'b1;
    #1;
    check("mr_pcsrc",  32'(PCSrc_e), 0);
    check("mr_regw",   32'(RegWrite_e), 0);
    check("mr_memw",   32'(MemWrite_e), 0);
    check("mr_alu",    32'(ALUControl_e), 0);
    check("mr_flags",  32'(Flags), 0);
    check("mr_cnt",    32'(squash_cnt), 0);
    check("mr_cond",   32'(dut.ctrl_e.cond), 32'hE);
    @(negedge clk);
    reset = 1'b0;

    // Sweep 16 conditions x 16 flag values
    for (int f = 0; f < 16; f++) begin
      set_d(4'hE, 0, 0, 0, 0, 0, 2'b11, 3'd0); tick();
      ALUFlags_e = 4'(f);
      for (int c = 0; c < 16; c++) begin
        set_d(4'(c), 0, 1, 0, 0, 0, 2'b00, 3'd0); tick();
        check($sformatf("sweep_c%0h_f%0h", c, f), 32'(CondEx_e),
              32'(cond_model(4'(c), 4'(f))));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
